// File: rtl/m_exc_pkg.sv
// Shared constants for the M-stage exception unit: mem_op encodings, ExcCodes
// and the default data-memory / device address map.
package m_exc_pkg;

  localparam logic [3:0] OpNone = 4'd0;
  localparam logic [3:0] OpLb   = 4'd1;
  localparam logic [3:0] OpLbu  = 4'd2;
  localparam logic [3:0] OpLh   = 4'd3;
  localparam logic [3:0] OpLhu  = 4'd4;
  localparam logic [3:0] OpLw   = 4'd5;
  localparam logic [3:0] OpSb   = 4'd6;
  localparam logic [3:0] OpSh   = 4'd7;
  localparam logic [3:0] OpSw   = 4'd8;

  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;

  localparam logic [31:0] DefDmBase   = 32'h0000_0000;
  localparam logic [31:0] DefDmSize   = 32'h0000_3000;
  localparam int          DefNDev     = 2;
  localparam logic [63:0] DefDevBase  = {32'h0000_7f10, 32'h0000_7f00};
  localparam logic [31:0] DefDevSpan  = 32'd12;
  localparam logic [31:0] DefDevRoOff = 32'd8;

  function automatic logic isStoreOp(input logic [3:0] op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

  function automatic logic isLoadOp(input logic [3:0] op);
    return (op >= OpLb) && (op <= OpLw);
  endfunction

endpackage

// File: rtl/m_exc_unit_class.sv
// Combinational address classifier: alignment, data-memory window and
// device windows (including the per-device read-only word).
module m_addr_class
  import m_exc_pkg::*;
#(
  parameter logic [31:0]          DM_BASE    = DefDmBase,
  parameter logic [31:0]          DM_SIZE    = DefDmSize,
  parameter int                   N_DEV      = DefNDev,
  parameter logic [N_DEV*32-1:0]  DEV_BASE   = DefDevBase,
  parameter logic [31:0]          DEV_SPAN   = DefDevSpan,
  parameter logic [31:0]          DEV_RO_OFF = DefDevRoOff
) (
  input  logic [31:0] addr,
  input  logic [3:0]  mem_op,
  output logic        misalign,
  output logic        in_dm,
  output logic        in_dev,
  output logic        ro_hit
);

  logic isHalf, isWord;
  logic [N_DEV-1:0] devHit, roVec;

  assign isHalf = (mem_op == OpLh) || (mem_op == OpLhu) || (mem_op == OpSh);
  assign isWord = (mem_op == OpLw) || (mem_op == OpSw);
  assign misalign = (isHalf && addr[0]) || (isWord && (addr[1:0] != 2'b00));

  // Upper bounds are compared at 33 bits so a window ending at 4 GiB cannot wrap.
  localparam logic [32:0] DmEnd = {1'b0, DM_BASE} + {1'b0, DM_SIZE};
  assign in_dm = ({1'b0, addr} >= {1'b0, DM_BASE}) && ({1'b0, addr} < DmEnd);

  for (genvar i = 0; i < N_DEV; i++) begin : gDev
    localparam logic [31:0] Base   = DEV_BASE[32*i +: 32];
    localparam logic [32:0] Lim    = {1'b0, Base} + {1'b0, DEV_SPAN};
    localparam logic [31:0] RoAddr = Base + DEV_RO_OFF;
    assign devHit[i] = (addr >= Base) && ({1'b0, addr} < Lim);
    assign roVec[i]  = (addr == RoAddr);
  end

  assign in_dev = |devHit;
  assign ro_hit = |roVec;

endmodule

// File: rtl/m_exc_unit.sv
// M-stage exception unit: priority fault mux, M/W stage register, held
// exception for CP0 and a saturating fault counter.
module m_exc_unit
  import m_exc_pkg::*;
#(
  parameter logic [31:0]          DM_BASE    = DefDmBase,
  parameter logic [31:0]          DM_SIZE    = DefDmSize,
  parameter int                   N_DEV      = DefNDev,
  parameter logic [N_DEV*32-1:0]  DEV_BASE   = DefDevBase,
  parameter logic [31:0]          DEV_SPAN   = DefDevSpan,
  parameter logic [31:0]          DEV_RO_OFF = DefDevRoOff,
  parameter int                   CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             pre_exc,
  input  logic [4:0]       pre_code,
  input  logic [3:0]       mem_op,
  input  logic [31:0]      addr,
  input  logic [31:0]      pc,
  output logic             w_valid,
  output logic             w_exc,
  output logic [4:0]       w_code,
  output logic             exc_pending,
  output logic [4:0]       exc_code,
  output logic [31:0]      bad_vaddr,
  output logic [31:0]      exc_pc,
  input  logic             exc_ack,
  output logic [CNT_W-1:0] fault_cnt
);

  logic misalign, inDm, inDev, roHit;
  logic isLoad, isStore, isWord;
  logic faultNow, slotFault, accept;
  logic [4:0] codeNow, accCode;

  m_addr_class #(
    .DM_BASE(DM_BASE), .DM_SIZE(DM_SIZE), .N_DEV(N_DEV),
    .DEV_BASE(DEV_BASE), .DEV_SPAN(DEV_SPAN), .DEV_RO_OFF(DEV_RO_OFF)
  ) uClass (
    .addr(addr), .mem_op(mem_op),
    .misalign(misalign), .in_dm(inDm), .in_dev(inDev), .ro_hit(roHit)
  );

  assign isLoad  = isLoadOp(mem_op);
  assign isStore = isStoreOp(mem_op);
  assign isWord  = (mem_op == OpLw) || (mem_op == OpSw);
  assign accCode = isStore ? ExcAdES : ExcAdEL;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    faultNow = 1'b0;
    codeNow  = 5'd0;
    if (pre_exc) begin
      faultNow = 1'b1;
      codeNow  = pre_code;
    end else if (isLoad || isStore) begin
      if (misalign || !(inDm || inDev)) begin
        faultNow = 1'b1;
        codeNow  = accCode;
      end else if (isStore && roHit) begin
        faultNow = 1'b1;
        codeNow  = ExcAdES;
      end else if (inDev && !isWord) begin
        faultNow = 1'b1;
        codeNow  = accCode;
      end
    end
  end

  assign slotFault = in_valid && faultNow;
  // Flush does not block acceptance: the check looks at this cycle's inputs.
  assign accept = slotFault && !stall && !exc_pending;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid <= 1'b0;
      w_exc   <= 1'b0;
      w_code  <= 5'd0;
    end else if (flush) begin
      w_valid <= 1'b0;
      w_exc   <= 1'b0;
      w_code  <= 5'd0;
    end else if (!stall) begin
      w_valid <= in_valid;
      w_exc   <= slotFault;
      w_code  <= slotFault ? codeNow : 5'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_pending <= 1'b0;
      exc_code    <= 5'd0;
      bad_vaddr   <= 32'd0;
      exc_pc      <= 32'd0;
    end else if (accept) begin
      exc_pending <= 1'b1;
      exc_code    <= codeNow;
      bad_vaddr   <= pre_exc ? 32'd0 : addr;
      exc_pc      <= pc;
    end else if (exc_ack) begin
      exc_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_cnt <= '0;
    end else if (accept && !(&fault_cnt)) begin
      fault_cnt <= fault_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/m_exc_unit.md
# m_exc_unit

Parametrised memory-stage exception unit for the pipelined MIPS CPU, sitting between the M-stage address/ByteSel logic and CP0. It classifies each load/store against alignment rules, the data-memory window and N_DEV memory-mapped device windows, including per-device read-only words. It merges the result with any exception carried from earlier stages and registers it into the M/W boundary. It also holds the first unacknowledged exception (code, BadVAddr, EPC) for CP0 and keeps a saturating fault counter.

## Interface
Parameters:
- DM_BASE, 32'h0000_0000, first byte address of data memory
- DM_SIZE, 32'h0000_3000, data-memory span in bytes
- N_DEV, 2, number of device windows (1..8)
- DEV_BASE, {32'h7f10, 32'h7f00}, packed N_DEV×32 base addresses; entry i is at [32i+31:32i]
- DEV_SPAN, 32'd12, bytes per device window
- DEV_RO_OFF, 32'd8, byte offset of the read-only word inside every device window
- CNT_W, 16, width of the fault counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold the stage register
- flush  in  1  clear the stage register (bubble)
- in_valid  in  1  M-stage slot holds a real instruction
- pre_exc  in  1  exception already raised upstream
- pre_code  in  5  upstream ExcCode
- mem_op  in  4  0 = none, 1 = LB, 2 = LBU, 3 = LH, 4 = LHU, 5 = LW, 6 = SB, 7 = SH, 8 = SW; 9–15 = none
- addr  in  32  effective byte address
- pc  in  32  instruction PC
- w_valid  out  1  registered slot valid
- w_exc  out  1  registered exception flag
- w_code  out  5  registered ExcCode
- exc_pending  out  1  held exception awaiting CP0
- exc_code  out  5  held code
- bad_vaddr  out  32  held faulting address; 0 when the exception came from pre_exc
- exc_pc  out  32  held PC
- exc_ack  in  1  CP0 has taken the held exception
- fault_cnt  out  CNT_W  saturating count of exceptions accepted

## Operation
- Decode: load = ops 1–5, store = ops 6–8. Half = LH, LHU, SH; word = LW, SW.
- Misalign: half with addr[0] set, or word with addr[1:0] ≠ 0.
- Range: in_dm = DM_BASE ≤ addr < DM_BASE + DM_SIZE. in_dev[i] = DEV_BASE[i] ≤ addr < DEV_BASE[i] + DEV_SPAN. in_dev = OR of all in_dev[i].
- Faults are checked in priority order; the first that matches sets the code:
  1. pre_exc → pre_code.
  2. Misalign → AdEL (load) / AdES (store).
  3. Outside both DM and every device window → AdEL / AdES.
  4. Store with addr = DEV_BASE[i] + DEV_RO_OFF for any i → AdES.
  5. Device access that is not word-sized → AdEL / AdES.
- AdEL = 5'd4 and AdES = 5'd5.
- Non-memory ops only ever propagate pre_exc.
- A fault counts only when in_valid = 1.
- Hold register:
  - A faulting slot is accepted when it is valid, the stage is not stalled, and nothing is pending.
  - On accept: exc_pending ← 1 and exc_code, bad_vaddr, exc_pc are latched.
  - Faults arriving while exc_pending = 1 are not latched. They still propagate on w_exc.
  - exc_ack clears exc_pending on the next edge.
  - If exc_ack and a new accept fall in the same cycle, the new exception is latched and exc_pending stays 1.
- fault_cnt increments on each accept and saturates at all-ones.

## Timing
- Reset values: every output is 0, including fault_cnt.
- Classification is combinational. w_* and the hold register update on the clk edge, so there is 1-cycle latency from inputs to w_*.
- Stage register priority: flush > stall > load.
  - flush: w_valid, w_exc and w_code become 0.
  - stall: the stage register holds its value.
  - Stall suppresses accept. Flush does not, because the check uses the current inputs.
- exc_ack while nothing is pending has no effect.
- Reset asserted mid-operation clears the pending exception and the counter immediately (asynchronous).

## Structure
- Shared package/define file holds: the mem_op encodings, ExcAdEL/ExcAdES, and the default DM/device constants.
- One sub-module, m_addr_class: purely combinational. Takes addr and mem_op; returns misalign, in_dm, in_dev and ro_hit. Device windows are built with a generate loop over N_DEV.
- The top level holds the priority mux, the stage register, the hold register and the counter.

## Test plan
- LW to 0x0000_0004, in_valid = 1 → next cycle w_valid = 1, w_exc = 0. exc_pending stays 0.
- LH to 0x0000_0011 → w_code = 4, exc_pending = 1, bad_vaddr = 0x11, exc_pc = pc, fault_cnt = 1.
- SW to 0x7f08 (RO word), then SB to 0x7f10 while still pending → both give w_code = 5. The hold register keeps bad_vaddr = 0x7f08. Assert exc_ack → exc_pending = 0 next cycle.
- LW to 0x0000_5000 with stall = 1 for 2 cycles, then stall = 0 → no accept while stalled; accept with code 4 in the cycle after stall drops.
- pre_exc = 1, pre_code = 10 (RI) with mem_op = 0 → w_code = 10, bad_vaddr = 0. Same cycle with flush = 1 → w_exc = 0 but exc_pending = 1.
- CNT_W = 2, 5 accepted faults with exc_ack between each → fault_cnt = 3 (saturated). Reset pulsed between clock edges → all outputs 0 immediately.
